// File: rtl/sort_result_streamer.sv
// Captures four sorted values on a rising edge of done, then streams them out one
// element per valid/ready handshake, along with their sum and an ordering flag.
module sort_result_streamer #(
   parameter int DIGIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [DIGIT-1:0] s0,
   input  logic [DIGIT-1:0] s1,
   input  logic [DIGIT-1:0] s2,
   input  logic [DIGIT-1:0] s3,
   input  logic             done,
   input  logic             out_ready,
   output logic [DIGIT-1:0] out_data,
   output logic [1:0]       out_index,
   output logic             out_valid,
   output logic             out_last,
   output logic [DIGIT+1:0] out_sum,
   output logic             order_err,
   output logic             overrun,
   output logic             busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_CAPTURE = 3'b010,
      ST_SEND    = 3'b100
   } state_t;

   state_t           state_q;
   logic             done_dly_q;
   logic [DIGIT-1:0] data_q [4];
   logic [1:0]       idx_q;
   logic [DIGIT-1:0] out_data_q;
   logic             out_valid_q;
   logic             out_last_q;
   logic [DIGIT+1:0] out_sum_q;
   logic             order_err_q;
   logic             overrun_q;
   logic             busy_q;

   logic             trigger;
   logic             in_flight;
   logic [1:0]       idx_nxt;

   // Two guard bits make the four-way sum overflow-free.
   function automatic logic [DIGIT+1:0] sum4(input logic [DIGIT-1:0] a, input logic [DIGIT-1:0] b,
                                             input logic [DIGIT-1:0] c, input logic [DIGIT-1:0] d);
      return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
   endfunction

   function automatic logic unordered4(input logic [DIGIT-1:0] a, input logic [DIGIT-1:0] b,
                                       input logic [DIGIT-1:0] c, input logic [DIGIT-1:0] d);
      return (a > b) | (b > c) | (c > d);
   endfunction

   assign trigger   = done & ~done_dly_q;
   assign in_flight = (state_q == ST_CAPTURE) | (state_q == ST_SEND);
   assign idx_nxt   = idx_q + 2'd1;

   // Single FSM register block; every output is a register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         done_dly_q  <= 1'b0;
         idx_q       <= 2'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_sum_q   <= '0;
         order_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         done_dly_q <= done;
         // A new trigger while a set is in flight is flagged and dropped.
         if (trigger && in_flight) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               out_valid_q <= 1'b0;
               if (trigger) begin
                  data_q[0] <= s0;
                  data_q[1] <= s1;
                  data_q[2] <= s2;
                  data_q[3] <= s3;
                  busy_q    <= 1'b1;
                  state_q   <= ST_CAPTURE;
               end else begin
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            ST_CAPTURE: begin
               out_sum_q   <= sum4(data_q[0], data_q[1], data_q[2], data_q[3]);
               order_err_q <= unordered4(data_q[0], data_q[1], data_q[2], data_q[3]);
               idx_q       <= 2'd0;
               out_data_q  <= data_q[0];
               out_last_q  <= 1'b0;
               out_valid_q <= 1'b1;
               busy_q      <= 1'b1;
               state_q     <= ST_SEND;
            end
            ST_SEND: begin
               if (out_valid_q && out_ready) begin
                  if (idx_q == 2'd3) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     state_q     <= ST_IDLE;
                  end else begin
                     idx_q       <= idx_nxt;
                     out_data_q  <= data_q[idx_nxt];
                     out_last_q  <= (idx_nxt == 2'd3);
                  end
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_index = idx_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_sum   = out_sum_q;
   assign order_err = order_err_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

endmodule

// File: doc/sort_result_streamer.md
SORT_RESULT_STREAMER -- requirements
Module: sort_result_streamer

Interface
REQ-001 Parameter: DIGIT, default 4, bit width of each sorted element.
REQ-002 Port: clock  input  1  the single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 Ports: s0, s1, s2, s3  input  DIGIT each  sorted values from the upstream sorter, with s0 as the intended minimum.
REQ-005 Port: done  input  1  upstream completion flag; it MAY stay high for many consecutive cycles.
REQ-006 Port: out_data  output  DIGIT  the current streamed element.
REQ-007 Port: out_index  output  2  position of out_data in the captured set, 0 to 3.
REQ-008 Port: out_valid  output  1  out_data, out_index and out_last are valid.
REQ-009 Port: out_ready  input  1  downstream accepts the element.
REQ-010 Port: out_last  output  1  high with element index 3.
REQ-011 Port: out_sum  output  DIGIT+2  sum of the four captured values; held until the next capture.
REQ-012 Port: order_err  output  1  the captured set was not non-decreasing; held until the next capture.
REQ-013 Port: overrun  output  1  sticky flag: a done rising edge arrived while busy.
REQ-014 Port: busy  output  1  high in states CAPTURE and SEND.

Function
REQ-015 The block SHALL register done as done_d every cycle; a trigger is defined as done=1 and done_d=0.
REQ-016 States SHALL be IDLE, CAPTURE and SEND, one-hot encoded, with any illegal encoding returning to IDLE on the next edge.
REQ-017 In IDLE, on a trigger, the block SHALL latch s0..s3 into buf0..buf3 and go to CAPTURE; without a trigger it stays in IDLE.
REQ-018 In CAPTURE, the block SHALL register out_sum and order_err from buf0..buf3, clear the index to 0, and go to SEND after exactly 1 cycle.
- order_err = (buf0>buf1) | (buf1>buf2) | (buf2>buf3), compared unsigned.
- out_sum is an unsigned sum, zero-extended; it SHALL never overflow.
REQ-019 In SEND, out_valid SHALL be 1 and out_data SHALL equal buf[index]; out_data, out_index and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 A transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
- On a transfer with index<3: index increments.
- On a transfer with index=3: go to IDLE and clear out_valid.
REQ-021 out_valid SHALL be 0 in IDLE and CAPTURE.
REQ-022 Latency: the first element SHALL be valid 2 cycles after the edge that samples the trigger.
- With out_ready held at 1, the four elements SHALL appear on 4 consecutive cycles.
REQ-023 A trigger seen in CAPTURE or SEND SHALL set overrun, SHALL NOT alter buf0..buf3 or the stream, and SHALL NOT be queued.
REQ-024 overrun SHALL clear only on reset.
REQ-025 If done stays high after the stream ends, no new capture SHALL occur until done falls and rises again.
REQ-026 If out_ready is high in a cycle where out_valid is low, it SHALL have no effect.

Reset
REQ-027 On reset=1 at a rising edge, from any state and also mid-stream, the block SHALL apply the following, and the in-progress stream SHALL be abandoned:
- state = IDLE
- out_valid = 0, out_last = 0, out_index = 0, out_data = 0
- out_sum = 0, order_err = 0, overrun = 0, busy = 0
- done_d = 0
- buf0..buf3 = 0
REQ-028 If done=1 while reset is asserted, a trigger SHALL be recognised on the first edge after reset deasserts, because done_d=0.

Verification
REQ-029 Basic stream: s={1,3,7,9}, done rises, out_ready=1 -> cycles +2..+5 show out_data 1,3,7,9 with out_index 0..3; out_last only on 9; out_sum=20; order_err=0.
REQ-030 Backpressure: same data with out_ready toggling 0,1,0,0,1... -> each element held stable until accepted; no element dropped or duplicated; out_valid falls after the 9 is accepted.
REQ-031 Order check and width: s={15,15,15,15} -> out_sum=60 (6 bits), order_err=0; s={5,2,8,9} -> order_err=1, streamed as 5,2,8,9.
REQ-032 Held done: done high for 20 cycles -> exactly one stream; done low for 1 cycle, then high -> second stream.
REQ-033 Overrun: during SEND, done pulses low then high with new data {0,0,0,0} -> overrun=1; current stream continues with the old values; overrun remains 1 after IDLE.
REQ-034 Reset mid-stream: reset after element 1 is accepted -> next edge: out_valid=0, busy=0, overrun=0, out_sum=0; no further elements emitted.
